pipe_hazard_ctrl: RTL and testbench

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/pipe_hazard_ctrl_if.sv | 31 +++
 rtl/pipe_hazard_ctrl.sv | 107 ++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/pipe_hazard_ctrl_if.sv
// rtl/pipe_hazard_ctrl_if.sv - hazard controller pipeline-side signal bundle
interface pipe_hazard_ctrl_if;
    logic [4:0]  IFID_Rs;
    logic [4:0]  IFID_Rt;
    logic        IFID_UsesRt;
    logic        IDEX_MemRead;
    logic [4:0]  IDEX_Rt;
    logic        BranchTaken;
    logic        LongOpStart;
    logic        ClearStats;
    logic        PCWrite;
    logic        IFIDWrite;
    logic        IFIDFlush;
    logic        IDEXBubble;
    logic        State;
    logic [15:0] StallCount;

    // Pipeline side: presents hazard information, consumes control enables
    modport master (
        output IFID_Rs, IFID_Rt, IFID_UsesRt, IDEX_MemRead, IDEX_Rt,
               BranchTaken, LongOpStart, ClearStats,
        input  PCWrite, IFIDWrite, IFIDFlush, IDEXBubble, State, StallCount
    );

    // Controller side
    modport slave (
        input  IFID_Rs, IFID_Rt, IFID_UsesRt, IDEX_MemRead, IDEX_Rt,
               BranchTaken, LongOpStart, ClearStats,
        output PCWrite, IFIDWrite, IFIDFlush, IDEXBubble, State, StallCount
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - load-use / branch / long-op pipeline hazard controller
module pipe_hazard_ctrl #(
    parameter int LONG_LAT = 3
) (
    input  logic               Clk,
    input  logic               Reset,
    pipe_hazard_ctrl_if.slave  hz
);

    typedef enum logic {
        RUN  = 1'b0,
        LONG = 1'b1
    } state_t;

    localparam logic [3:0] CNT_LOAD = 4'(LONG_LAT - 1);

    state_t      state_q;
    logic [3:0]  cnt_q;
    logic [15:0] stall_q;

    logic lu;
    logic start_long;
    logic pc_write;
    logic ifid_write;
    logic ifid_flush;
    logic idex_bubble;

    // Load-use: a load in ID/EX targets a register the IF/ID instruction reads; r0 never hazards
    assign lu = hz.IDEX_MemRead & (hz.IDEX_Rt != 5'd0) &
                ((hz.IDEX_Rt == hz.IFID_Rs) |
                 (hz.IFID_UsesRt & (hz.IDEX_Rt == hz.IFID_Rt)));

    assign start_long = (state_q == RUN) & ~lu & ~hz.BranchTaken & hz.LongOpStart;

    // Same-cycle control enables; priority LU > branch > long-op start > free-run
    always_comb begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        if (!Reset) begin
            if (state_q == LONG) begin
                idex_bubble = 1'b1;
            end else if (lu) begin
                idex_bubble = 1'b1;
            end else if (hz.BranchTaken) begin
                pc_write   = 1'b1;
                ifid_write = 1'b1;
                ifid_flush = 1'b1;
            end else if (hz.LongOpStart) begin
                // long op moves into ID/EX while fetch is frozen
                pc_write   = 1'b0;
            end else begin
                pc_write   = 1'b1;
                ifid_write = 1'b1;
            end
        end
    end

    // Mode tracking: RUN, or LONG counting down the remaining execute cycles
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= RUN;
            cnt_q   <= 4'd0;
        end else begin
            case (state_q)
                RUN: begin
                    if (start_long) begin
                        state_q <= LONG;
                        cnt_q   <= CNT_LOAD;
                    end
                end
                LONG: begin
                    if (cnt_q <= 4'd1) begin
                        state_q <= RUN;
                        cnt_q   <= 4'd0;
                    end else begin
                        cnt_q   <= cnt_q - 4'd1;
                    end
                end
                default: begin
                    state_q <= RUN;
                    cnt_q   <= 4'd0;
                end
            endcase
        end
    end

    // Saturating count of frozen-PC cycles; clear wins over a same-edge increment
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            stall_q <= 16'd0;
        end else if (hz.ClearStats) begin
            stall_q <= 16'd0;
        end else if (!pc_write && (stall_q != 16'hFFFF)) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign hz.PCWrite    = pc_write;
    assign hz.IFIDWrite  = ifid_write;
    assign hz.IFIDFlush  = ifid_flush;
    assign hz.IDEXBubble = idex_bubble;
    assign hz.State      = state_q;
    assign hz.StallCount = stall_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - vector and sequence bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;

    logic Clk;
    logic Reset;

    pipe_hazard_ctrl_if hz();

    pipe_hazard_ctrl #(.LONG_LAT(3)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .hz    (hz)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic [4:0] rs;
        logic [4:0] rt;
        logic       uses_rt;
        logic       memrd;
        logic [4:0] idex_rt;
        logic       br;
        logic       los;
        logic       clr;
        logic       pcw;
        logic       ifw;
        logic       fl;
        logic       bub;
        logic       st;
    } vec_t;

    localparam int NV = 20;
    vec_t vecs [NV];
    vec_t sb [$];

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_stall;

    function automatic vec_t mk(input logic [4:0] rs, input logic [4:0] rt, input logic uses_rt,
                                input logic memrd, input logic [4:0] idex_rt, input logic br,
                                input logic los, input logic clr, input logic pcw, input logic ifw,
                                input logic fl, input logic bub, input logic st);
        vec_t v;
        v.rs = rs; v.rt = rt; v.uses_rt = uses_rt; v.memrd = memrd; v.idex_rt = idex_rt;
        v.br = br; v.los = los; v.clr = clr;
        v.pcw = pcw; v.ifw = ifw; v.fl = fl; v.bub = bub; v.st = st;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        hz.IFID_Rs      = v.rs;
        hz.IFID_Rt      = v.rt;
        hz.IFID_UsesRt  = v.uses_rt;
        hz.IDEX_MemRead = v.memrd;
        hz.IDEX_Rt      = v.idex_rt;
        hz.BranchTaken  = v.br;
        hz.LongOpStart  = v.los;
        hz.ClearStats   = v.clr;
    endtask

    initial begin
        vec_t v;
        vec_t idle;
        vec_t lu_v;

        //             rs     rt     ur    mr    irt    br    los   clr   pcw   ifw   fl    bub   st
        vecs[0]  = mk(5'd1,  5'd2,  1'b1, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        vecs[1]  = mk(5'd8,  5'd2,  1'b0, 1'b1, 5'd8,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        vecs[2]  = mk(5'd8,  5'd2,  1'b0, 1'b0, 5'd8,  1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        vecs[3]  = mk(5'd0,  5'd0,  1'b1, 1'b1, 5'd0,  1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        vecs[4]  = mk(5'd3,  5'd5,  1'b0, 1'b1, 5'd5,  1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        vecs[5]  = mk(5'd3,  5'd5,  1'b1, 1'b1, 5'd5,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        vecs[6]  = mk(5'd8,  5'd2,  1'b0, 1'b1, 5'd8,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        vecs[7]  = mk(5'd8,  5'd2,  1'b0, 1'b0, 5'd8,  1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        vecs[8]  = mk(5'd1,  5'd2,  1'b0, 1'b0, 5'd0,  1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        vecs[9]  = mk(5'd1,  5'd2,  1'b0, 1'b0, 5'd0,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        vecs[10] = mk(5'd8,  5'd2,  1'b0, 1'b1, 5'd8,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        vecs[11] = mk(5'd1,  5'd2,  1'b0, 1'b0, 5'd0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        vecs[12] = mk(5'd1,  5'd2,  1'b0, 1'b0, 5'd0,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        vecs[13] = mk(5'd1,  5'd2,  1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        vecs[14] = mk(5'd1,  5'd2,  1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        vecs[15] = mk(5'd7,  5'd9,  1'b1, 1'b1, 5'd9,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        vecs[16] = mk(5'd1,  5'd2,  1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        vecs[17] = mk(5'd1,  5'd2,  1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        vecs[18] = mk(5'd8,  5'd2,  1'b0, 1'b1, 5'd8,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        vecs[19] = mk(5'd8,  5'd2,  1'b0, 1'b1, 5'd8,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        idle = mk(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        lu_v = vecs[1];

        // Reset state, including an LU pattern on the inputs that must be masked
        Reset = 1'b1;
        drive(lu_v);
        #2;
        check("rst_pcw",   hz.PCWrite,    0);
        check("rst_ifw",   hz.IFIDWrite,  0);
        check("rst_flush", hz.IFIDFlush,  0);
        check("rst_bub",   hz.IDEXBubble, 0);
        check("rst_state", hz.State,      0);
        check("rst_stall", hz.StallCount, 0);
        repeat (2) @(posedge Clk);
        #1;
        check("rst_stall_hold", hz.StallCount, 0);
        Reset = 1'b0;
        exp_stall = 16'd0;

        // Table vectors, one cycle each, through the scoreboard
        for (int i = 0; i < NV; i++) begin
            drive(vecs[i]);
            sb.push_back(vecs[i]);
            #3;
            v = sb.pop_front();
            check($sformatf("v%0d_pcw", i),   hz.PCWrite,    v.pcw);
            check($sformatf("v%0d_ifw", i),   hz.IFIDWrite,  v.ifw);
            check($sformatf("v%0d_flush", i), hz.IFIDFlush,  v.fl);
            check($sformatf("v%0d_bub", i),   hz.IDEXBubble, v.bub);
            check($sformatf("v%0d_state", i), hz.State,      v.st);
            check($sformatf("v%0d_excl", i),  hz.IFIDFlush & ~hz.IFIDWrite, 0);
            if (v.clr)
                exp_stall = 16'd0;
            else if (!v.pcw && exp_stall != 16'hFFFF)
                exp_stall = exp_stall + 16'd1;
            @(posedge Clk);
            #1;
            check($sformatf("v%0d_stall", i), hz.StallCount, exp_stall);
        end

        // Isolated long op: 1 start + 2 LONG cycles adds exactly 3 stalls
        drive(idle);
        idle.clr = 1'b1;
        drive(idle);
        @(posedge Clk);
        #1;
        idle.clr = 1'b0;
        drive(idle);
        check("lo_clr", hz.StallCount, 0);
        v = idle;
        v.los = 1'b1;
        drive(v);
        @(posedge Clk);
        #1;
        drive(idle);
        repeat (2) @(posedge Clk);
        #1;
        check("lo_state_run", hz.State, 0);
        check("lo_pcw", hz.PCWrite, 1);
        check("lo_stall3", hz.StallCount, 3);

        // Reset between edges while in LONG
        drive(v);
        @(posedge Clk);
        #1;
        drive(idle);
        #2;
        check("mid_long_state", hz.State, 1);
        Reset = 1'b1;
        #1;
        check("mr_state", hz.State,      0);
        check("mr_stall", hz.StallCount, 0);
        check("mr_pcw",   hz.PCWrite,    0);
        check("mr_ifw",   hz.IFIDWrite,  0);
        check("mr_flush", hz.IFIDFlush,  0);
        check("mr_bub",   hz.IDEXBubble, 0);
        @(posedge Clk);
        #1;
        Reset = 1'b0;
        drive(lu_v);
        #2;
        check("post_rst_pcw", hz.PCWrite,    0);
        check("post_rst_bub", hz.IDEXBubble, 1);
        check("post_rst_st",  hz.State,      0);
        @(posedge Clk);
        #1;
        check("post_rst_stall", hz.StallCount, 1);

        // Continuous stall to saturation, then clear during the stall
        repeat (65540) @(posedge Clk);
        #1;
        check("sat_ffff", hz.StallCount, 16'hFFFF);
        @(posedge Clk);
        #1;
        check("sat_hold", hz.StallCount, 16'hFFFF);
        v = lu_v;
        v.clr = 1'b1;
        drive(v);
        @(posedge Clk);
        #1;
        check("sat_clr", hz.StallCount, 0);
        drive(lu_v);
        @(posedge Clk);
        #1;
        check("sat_after_clr", hz.StallCount, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
